// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_pcnext.sv
// Next-PC selection: jump target, taken branch, or sequential pc+4.
module pcnext (
  input  logic [31:0] pcplus4,
  input  logic [25:0] instr_index,
  input  logic [31:0] signimm,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] npc
);

  // Jump outranks branch when the controller raises both.
  always_comb begin
    npc = pcplus4;
    if (jump)
      npc = {pcplus4[31:28], instr_index, 2'b00};
    else if (pcsrc)
      npc = pcplus4 + (signimm << 2);
  end

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch and PC sequencing: fetch one word, hold it for execute, commit next PC.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] retired
);

  fetch_state_t state_q, state_d;
  logic [31:0]  npc;

  assign pcplus4   = pc + 32'd4;
  assign imem_addr = pc;

  pcnext u_pcnext (
    .pcplus4     (pcplus4),
    .instr_index (instr[25:0]),
    .signimm     (signimm),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .npc         (npc)
  );

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (advance) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ready)
        instr <= imem_rdata;
      if (state_q == S_EXEC && advance) begin
        pc      <= npc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction-fetch and PC-sequencing stage for the MIPS core. Holds the program counter, fetches one word per instruction over a ready/valid instruction-memory port, presents it to decode, and on `advance` selects the next PC from the branch/jump decisions (`pcsrc`, `jump`) produced by the controller. Sits directly upstream of the controller/datapath; it is the sole consumer of their PC-control outputs.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; `imem_addr` valid while high.
- `imem_addr`  out  32  byte address of requested word (= `pc`).
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  held instruction for decode.
- `instr_valid`  out  1  `instr` valid; decode/execute may proceed.
- `pc`  out  32  address of current instruction.
- `pcplus4`  out  32  `pc + 4`, combinational.
- `advance`  in  1  execute stage finished; commit next PC.
- `pcsrc`  in  1  taken branch (from controller).
- `jump`  in  1  J-type jump (from controller).
- `signimm`  in  32  sign-extended immediate from datapath.
- `retired`  out  32  count of committed instructions.

## Operation
- States: `S_IDLE`, `S_FETCH`, `S_EXEC`.
- `S_IDLE`: entered on reset; all outputs at reset value; next cycle -> `S_FETCH` unconditionally.
- `S_FETCH`: `imem_req`=1, `imem_addr`=`pc`. On edge with `imem_ready`=1: `instr`<=`imem_rdata`, -> `S_EXEC`. Else stay; `pc` stable.
- `S_EXEC`: `instr_valid`=1, `instr` held stable. On edge with `advance`=1: `pc`<=next PC, `retired`<=`retired`+1, -> `S_FETCH`. Else stay.
- Next PC (32-bit, modulo 2^32): `jump`=1 -> {`pcplus4`[31:28], `instr`[25:0], 2'b00}; else `pcsrc`=1 -> `pcplus4` + (`signimm` << 2); else `pcplus4`. `jump` has priority when both high.
- `pcsrc`, `jump`, `signimm` sampled only at an `advance` edge in `S_EXEC`; ignored otherwise.
- `imem_ready`, `imem_rdata` ignored outside `S_FETCH`; `advance` ignored outside `S_EXEC`.
- PC wrap: `pc`=32'hFFFF_FFFC sequential -> 32'h0000_0000.
- `retired` wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset values (asynchronous, immediate): state=`S_IDLE`, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `retired`=0.
- Reset mid-fetch or mid-execute: request dropped immediately; no PC commit; pending memory response discarded.
- Deassertion of reset -> `imem_req` high on the second rising edge (one `S_IDLE` cycle).
- Fetch latency: minimum one cycle (`imem_ready` already high in first `S_FETCH` cycle); `instr_valid` rises the cycle after the accepting edge.
- Best-case throughput: one instruction per 2 cycles (FETCH + EXEC with `advance` high).
- `imem_req`, `instr_valid` are registered-state decodes, glitch-free, mutually exclusive.
- `pcplus4`, `imem_addr` combinational from the `pc` register.

## Structure
- Shared package `mips_pkg`: state enum `fetch_state_t` {`S_IDLE`,`S_FETCH`,`S_EXEC`}, constant `DEFAULT_RESET_PC`.
- One sub-module: `pcnext` — combinational next-PC mux (`pcplus4`, `instr`[25:0], `signimm`, `pcsrc`, `jump` -> `pcnext`); reusable by the later multicycle core.
- Top holds FSM, PC/instr/retired registers.

## Test plan
- Reset, `RESET_PC`=0, `imem_ready` tied 1, `advance` tied 1, no branch -> `imem_addr` 0,4,8,12 every 2 cycles; `retired` increments each commit.
- At `pc`=0x10, `pcsrc`=1, `signimm`=32'hFFFF_FFFE, `advance`=1 -> next `imem_addr`=0x0C.
- At `pc`=0x0040_0000, `instr`[25:0]=26'h010_0004, `jump`=1 and `pcsrc`=1 together -> next PC 0x0040_0010 (jump wins).
- `imem_ready` low 3 cycles in `S_FETCH` -> `imem_req` high 4 cycles, `pc` stable, `instr_valid` rises after accept; `advance` held low 5 cycles -> `instr` unchanged, `retired` unchanged.
- Assert `reset` mid-`S_FETCH` with `imem_ready`=1 same cycle -> instruction not latched, `pc`=`RESET_PC`, `instr_valid`=0 immediately.
- `pc`=32'hFFFF_FFFC sequential advance -> `pc`=0; `retired` preset-by-run to 32'hFFFF_FFFF commit -> 0.
